// File: rtl/scenario_pkg.sv
// Shared types, constants and the per-sprite initial-condition generator
// used by scenario_loader.
package scenario_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic signed [31:0] UNIT_POS = 32'sh0100_0000;
  localparam logic signed [31:0] BASE_VEL = 32'sh0010_0000;
  localparam logic signed [31:0] STEP_POS = 32'sh0080_0000;

  typedef struct packed {
    logic [31:0] loc_x;
    logic [31:0] loc_y;
    logic [31:0] vel_x;
    logic [31:0] vel_y;
  } entry_t;

  // Location/velocity of sprite idx for a scenario; unknown scenarios yield all zero.
  function automatic entry_t scenario_entry(input logic [7:0]  scen,
                                            input logic [15:0] idx,
                                            input logic [3:0]  shift,
                                            input logic [15:0] sprites);
    entry_t             e;
    logic signed [31:0] mag;
    logic signed [31:0] vel;
    logic signed [31:0] ii;
    logic signed [31:0] half;
    logic signed [31:0] pair;
    e    = '0;
    mag  = UNIT_POS * (32'sd1 + $signed({18'd0, idx[15:2]}));
    vel  = BASE_VEL >>> shift;
    ii   = $signed({16'd0, idx});
    half = $signed({17'd0, sprites[15:1]});
    pair = $signed({17'd0, idx[15:1]});
    case (scen)
      8'd0, 8'd1: begin
        case (idx[1:0])
          2'd0:    begin e.loc_x = mag;  e.loc_y = mag;  end
          2'd1:    begin e.loc_x = -mag; e.loc_y = -mag; end
          2'd2:    begin e.loc_x = -mag; e.loc_y = mag;  end
          2'd3:    begin e.loc_x = mag;  e.loc_y = -mag; end
          default: begin e.loc_x = 32'd0; e.loc_y = 32'd0; end
        endcase
        if (scen == 8'd1) begin
          e.vel_x = idx[0] ? -vel : vel;
        end else begin
          e.vel_x = 32'd0;
        end
      end
      8'd2: begin
        e.loc_x = (ii - half) * STEP_POS;
      end
      8'd3: begin
        e.loc_y = pair * STEP_POS;
        if (idx[0]) begin
          e.loc_x = UNIT_POS;
          e.vel_x = -vel;
        end else begin
          e.loc_x = -UNIT_POS;
          e.vel_x = vel;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus saturating stable-high counter; emits one
// accept pulse per press once the button has been high long enough.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_accept
);

  logic        r_meta;
  logic        r_sync;
  logic [15:0] r_cnt;
  logic        r_accept;

  // Counter saturates at the threshold so a held button only fires once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_cnt    <= 16'd0;
      r_accept <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      if (!r_sync) begin
        r_cnt <= 16'd0;
      end else if (r_cnt != DEBOUNCE_CYCLES) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      r_accept <= r_sync && (r_cnt == (DEBOUNCE_CYCLES - 16'd1));
    end
  end

  assign o_accept = r_accept;

endmodule

// File: rtl/scenario_loader.sv
// Latches a switch-selected scenario on reset or debounced button press,
// writes the sprite table one entry per cycle, then releases the engine reset.
module scenario_loader
  import scenario_pkg::*;
#(
  parameter int          SPRITES         = 4,
  parameter int          DIMENSIONS      = 2,
  parameter int          WIDTH           = 32,
  parameter int          NUM_SCENARIOS   = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  HOLD_CYCLES     = 8'd16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [15:0]                                  sel,
  input  logic                                         load_btn,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] init_locations,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] init_velos,
  output logic                                         engine_rst_n,
  output logic                                         busy,
  output logic                                         sel_invalid,
  output logic [7:0]                                   active_scenario
);

  localparam int         IDX_W      = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam logic [8:0] NUM_SCEN_L = 9'(NUM_SCENARIOS);

  state_t r_state;
  state_t w_next_state;

  logic [15:0]      r_sel_meta;
  logic [15:0]      r_sel_sync;
  logic             r_auto_load;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_hold_cnt;
  logic [3:0]       r_shift;
  logic             r_engine_rst_n;
  logic             r_busy;
  logic             r_sel_invalid;
  logic [7:0]       r_active;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] r_locs;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] r_velos;

  logic       w_accept;
  logic       w_last_sprite;
  logic       w_hold_done;
  logic       w_latch;
  logic       w_write;
  logic       w_rearm;
  logic       w_busy_d;
  logic       w_engine_rst_n_d;
  logic       w_sel_oor;
  entry_t     w_entry;
  logic [WIDTH-1:0] w_loc_x;
  logic [WIDTH-1:0] w_loc_y;
  logic [WIDTH-1:0] w_vel_x;
  logic [WIDTH-1:0] w_vel_y;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (load_btn),
    .o_accept(w_accept)
  );

  assign w_last_sprite = (r_idx == IDX_W'(SPRITES - 1));
  assign w_hold_done   = (r_hold_cnt >= (HOLD_CYCLES - 8'd1));
  assign w_sel_oor     = ({1'b0, r_sel_sync[7:0]} >= NUM_SCEN_L);

  assign w_entry = scenario_entry(r_active, 16'(r_idx), r_shift, 16'(SPRITES));
  assign w_loc_x = WIDTH'($signed(w_entry.loc_x));
  assign w_loc_y = WIDTH'($signed(w_entry.loc_y));
  assign w_vel_x = WIDTH'($signed(w_entry.vel_x));
  assign w_vel_y = WIDTH'($signed(w_entry.vel_y));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; requests arriving in LOAD/HOLD are simply not looked at.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_auto_load || w_accept) w_next_state = LOAD;
        else                         w_next_state = IDLE;
      end
      LOAD: begin
        if (w_last_sprite) w_next_state = HOLD;
        else               w_next_state = LOAD;
      end
      HOLD: begin
        if (w_hold_done) w_next_state = RUN;
        else             w_next_state = HOLD;
      end
      RUN: begin
        if (w_accept) w_next_state = IDLE;
        else          w_next_state = RUN;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode; status flags are registered from the upcoming state.
  always_comb begin
    w_latch          = (r_state == IDLE) && (r_auto_load || w_accept);
    w_write          = (r_state == LOAD);
    w_rearm          = (r_state == RUN) && w_accept;
    w_busy_d         = (w_next_state == LOAD) || (w_next_state == HOLD);
    w_engine_rst_n_d = (w_next_state == RUN);
  end

  // Datapath: switch sync, scenario latch, table writes, hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_meta     <= 16'd0;
      r_sel_sync     <= 16'd0;
      r_auto_load    <= 1'b1;
      r_idx          <= '0;
      r_hold_cnt     <= 8'd0;
      r_shift        <= 4'd0;
      r_engine_rst_n <= 1'b0;
      r_busy         <= 1'b0;
      r_sel_invalid  <= 1'b0;
      r_active       <= 8'd0;
      r_locs         <= '0;
      r_velos        <= '0;
    end else begin
      r_sel_meta     <= sel;
      r_sel_sync     <= r_sel_meta;
      r_engine_rst_n <= w_engine_rst_n_d;
      r_busy         <= w_busy_d;

      // A request seen in RUN is replayed through IDLE via the auto-load flag.
      if (w_latch) begin
        r_auto_load   <= 1'b0;
        r_idx         <= '0;
        r_shift       <= r_sel_sync[11:8];
        r_sel_invalid <= w_sel_oor;
        r_active      <= w_sel_oor ? 8'd0 : r_sel_sync[7:0];
      end else if (w_rearm) begin
        r_auto_load <= 1'b1;
      end else begin
        r_auto_load <= r_auto_load;
      end

      if (w_write) begin
        for (int d = 0; d < DIMENSIONS; d++) begin
          if (d == 0) begin
            r_locs[r_idx][d]  <= w_loc_x;
            r_velos[r_idx][d] <= w_vel_x;
          end else if (d == 1) begin
            r_locs[r_idx][d]  <= w_loc_y;
            r_velos[r_idx][d] <= w_vel_y;
          end else begin
            r_locs[r_idx][d]  <= '0;
            r_velos[r_idx][d] <= '0;
          end
        end
        if (w_last_sprite) r_idx <= '0;
        else               r_idx <= r_idx + IDX_W'(1);
      end

      if (r_state == HOLD) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end else begin
        r_hold_cnt <= 8'd0;
      end
    end
  end

  assign init_locations  = r_locs;
  assign init_velos      = r_velos;
  assign engine_rst_n    = r_engine_rst_n;
  assign busy            = r_busy;
  assign sel_invalid     = r_sel_invalid;
  assign active_scenario = r_active;

endmodule
